// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with a 2-FF input synchroniser and mid-bit sampling.
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset (0 = reset)
//   rx         serial line, idle high, asynchronous to clk
//   data       last correctly received byte
//   valid      one-cycle pulse: data updated with a new byte
//   frame_err  one-cycle pulse: stop bit sampled low, byte discarded
//   busy       high while a frame is being received
module uart_rx #(
  parameter int unsigned BAUD = 9600,
  parameter int unsigned F    = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned N     = (F + BAUD / 2) / BAUD;
  localparam int unsigned HALF  = N / 2;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(HALF - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic             rx_meta;
  logic             rx_s;
  logic             rx_d;
  logic             fall_c;

  logic [1:0]       state_q;
  logic [1:0]       state_nx;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_nx;
  logic [2:0]       bit_q;
  logic [2:0]       bit_nx;
  logic [7:0]       shift_q;
  logic [7:0]       shift_nx;
  logic [7:0]       data_nx;
  logic             valid_nx;
  logic             frame_err_nx;
  logic             busy_nx;

  // Synchroniser plus one delay stage for edge detection; all idle high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_d    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_d    <= rx_s;
    end
  end

  // A frame only starts on a real high-to-low transition, never on a held-low line.
  assign fall_c = rx_d & ~rx_s;

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      data      <= 8'h00;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_nx;
      cnt_q     <= cnt_nx;
      bit_q     <= bit_nx;
      shift_q   <= shift_nx;
      data      <= data_nx;
      valid     <= valid_nx;
      frame_err <= frame_err_nx;
      busy      <= busy_nx;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nx     = state_q;
    cnt_nx       = cnt_q + CNT_W'(1);
    bit_nx       = bit_q;
    shift_nx     = shift_q;
    data_nx      = data;
    valid_nx     = 1'b0;
    frame_err_nx = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_nx = '0;
        if (fall_c) begin
          state_nx = START;
        end
      end
      START: begin
        // Mid-start check rejects short glitches on the line.
        if (cnt_q == CNT_MID) begin
          cnt_nx = '0;
          if (!rx_s) begin
            bit_nx   = 3'd0;
            state_nx = DATA;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_nx   = '0;
          shift_nx = {rx_s, shift_q[7:1]};
          bit_nx   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_nx = STOP;
          end
        end
      end
      STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_nx   = '0;
          state_nx = IDLE;
          if (rx_s) begin
            data_nx  = shift_q;
            valid_nx = 1'b1;
          end else begin
            frame_err_nx = 1'b1;
          end
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase

    busy_nx = (state_nx != IDLE);
  end

endmodule
